icache: RTL and testbench

Direct-mapped instruction cache that is the responder for the fetch stage's pipelined memory port. It registers the address on every `mem_submit`, returns one `I_SIZE` instruction word with a single-cycle `mem_ack`, and refills missing lines word by word from a backing memory bus. It sits between fetch and the instruction memory or bus arbiter.

---
 rtl/icache.sv | 134 +++++++++++++
 tb/tb_icache.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// icache: direct-mapped instruction cache answering the fetch port with
// single-cycle acks and refilling missed lines word by word over the backing bus.
module icache #(
  parameter int unsigned RW         = 16,
  parameter int unsigned I_SIZE     = 32,
  parameter int unsigned SETS       = 16,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [RW-1:0]     mem_addr,
  input  logic              mem_submit,
  output logic [I_SIZE-1:0] mem_data,
  output logic              mem_ack,
  input  logic              i_inv,
  output logic [RW-1:0]     mb_addr,
  output logic              mb_req,
  input  logic [I_SIZE-1:0] mb_data,
  input  logic              mb_ack
);

  localparam int unsigned OB = $clog2(LINE_WORDS);
  localparam int unsigned IB = $clog2(SETS);
  localparam int unsigned AW = OB + IB;
  localparam int unsigned TB = RW - AW;
  localparam int unsigned DW = SETS * LINE_WORDS;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_REFILL = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [RW-1:0]     r_req_addr;
  logic [OB-1:0]     r_beat;
  logic              r_inv_seen;
  logic              r_filled;
  logic [SETS-1:0]   r_valid;
  logic [TB-1:0]     r_tag  [SETS];
  logic [I_SIZE-1:0] r_data [DW];

  logic [IB-1:0]     w_idx;
  logic [TB-1:0]     w_tag;
  logic              w_tag_match;
  logic              w_hit;
  logic              w_miss;
  logic              w_accept;
  logic              w_beat_ack;
  logic              w_last_beat;

  assign w_idx       = r_req_addr[AW-1:OB];
  assign w_tag       = r_req_addr[RW-1:AW];
  assign w_tag_match = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  // The lookup right after a refill always answers, even if an invalidate
  // arrived during the refill and left the line invalid for later requests.
  assign w_hit       = (r_state == S_LOOKUP) && (r_filled || w_tag_match);
  assign w_miss      = (r_state == S_LOOKUP) && !(r_filled || w_tag_match);
  assign w_accept    = mem_submit && ((r_state == S_IDLE) || w_hit);
  assign w_beat_ack  = (r_state == S_REFILL) && mb_ack;
  assign w_last_beat = w_beat_ack && (r_beat == OB'(LINE_WORDS - 1));

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (mem_submit) w_state_nxt = S_LOOKUP;
      S_LOOKUP: begin
        if (w_hit) w_state_nxt = mem_submit ? S_LOOKUP : S_IDLE;
        else       w_state_nxt = S_REFILL;
      end
      S_REFILL: if (w_last_beat) w_state_nxt = S_LOOKUP;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from registered state; data is zero outside the ack cycle
  always_comb begin
    mem_ack  = 1'b0;
    mem_data = '0;
    mb_req   = 1'b0;
    mb_addr  = '0;
    case (r_state)
      S_LOOKUP: begin
        if (w_hit) begin
          mem_ack  = 1'b1;
          mem_data = r_data[r_req_addr[AW-1:0]];
        end
      end
      S_REFILL: begin
        mb_req  = 1'b1;
        mb_addr = {r_req_addr[RW-1:OB], r_beat};
      end
      default: ;
    endcase
  end

  // Request address, beat counter, valid bits and invalidate bookkeeping
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_req_addr <= '0;
      r_beat     <= '0;
      r_inv_seen <= 1'b0;
      r_filled   <= 1'b0;
      r_valid    <= '0;
    end else begin
      r_filled <= w_last_beat;
      if (w_accept) r_req_addr <= mem_addr;
      if (w_miss) begin
        r_beat     <= '0;
        r_inv_seen <= 1'b0;
      end else if (w_beat_ack) begin
        r_beat <= r_beat + OB'(1);
      end
      if ((r_state == S_REFILL) && i_inv) r_inv_seen <= 1'b1;
      if (i_inv) r_valid <= '0;
      if (w_last_beat) r_valid[w_idx] <= ~(r_inv_seen | i_inv);
    end
  end

  // Tag and data arrays: written only by refill beats, never reset
  always_ff @(posedge i_clk) begin
    if (w_beat_ack)  r_data[{w_idx, r_beat}] <= mb_data;
    if (w_last_beat) r_tag[w_idx] <= w_tag;
  end

endmodule

// File: tb/tb_icache.sv
// tb_icache: random and directed fetch traffic against a line-level cache model.
module tb_icache;

  localparam int NCYC = 6000;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [15:0] mem_addr;
  logic        mem_submit;
  logic [31:0] mem_data;
  logic        mem_ack;
  logic        i_inv;
  logic [15:0] mb_addr;
  logic        mb_req;
  logic [31:0] mb_data;
  logic        mb_ack;

  icache #(.RW(16), .I_SIZE(32), .SETS(16), .LINE_WORDS(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .mem_addr(mem_addr), .mem_submit(mem_submit),
    .mem_data(mem_data), .mem_ack(mem_ack),
    .i_inv(i_inv),
    .mb_addr(mb_addr), .mb_req(mb_req),
    .mb_data(mb_data), .mb_ack(mb_ack)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // Expected per-cycle outputs (default: everything zero)
  bit          e_ack [NCYC];
  logic [31:0] e_data[NCYC];
  bit          e_req [NCYC];
  logic [15:0] e_mba [NCYC];

  // Line-level cache model
  bit          m_valid[16];
  bit   [9:0]  m_tag  [16];
  logic [31:0] m_data [16][4];

  logic [15:0] salt = 16'h0;
  int          kcur = 0;
  bit          force_ack = 0;
  int          inv_sched = -1;
  int          wait_cnt = 0;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {salt, a} ^ 32'hA5A50000;
  endfunction

  // Backing memory: acks kcur cycles after the request is seen
  always @(negedge i_clk) begin
    if (force_ack) begin
      mb_ack = 1'b1; mb_data = mem_word(mb_addr); wait_cnt = 0;
    end else if (mb_req) begin
      if (wait_cnt == kcur) begin
        mb_ack = 1'b1; mb_data = mem_word(mb_addr); wait_cnt = 0;
      end else begin
        mb_ack = 1'b0; mb_data = $urandom; wait_cnt++;
      end
    end else begin
      mb_ack = 1'b0; mb_data = $urandom; wait_cnt = 0;
    end
  end

  // Invalidate pulse on the scheduled cycle
  always @(negedge i_clk) i_inv = (cyc == inv_sched);

  task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, got, exp, cyc);
    end
  endtask

  task automatic run_to(input int t);
    while (cyc < t) @(negedge i_clk);
  endtask

  // Issue one request in the current cycle and record what must follow
  task automatic submit(input logic [15:0] a, input int k, input int inv_off, output int ack_cyc);
    int c, idx, off, w;
    bit [9:0] tg;
    bit hit;
    c   = cyc;
    idx = int'(a[5:2]);
    off = int'(a[1:0]);
    tg  = a[15:6];
    kcur = k;
    hit = m_valid[idx] && (m_tag[idx] == tg);
    if (hit) begin
      ack_cyc = c + 1;
    end else begin
      for (int b = 0; b < 4; b++) begin
        m_data[idx][b] = mem_word({a[15:2], 2'(b)});
        for (int t = 0; t <= k; t++) begin
          w = c + 2 + b * (k + 1) + t;
          e_req[w] = 1'b1;
          e_mba[w] = {a[15:2], 2'(b)};
        end
      end
      ack_cyc = c + 2 + 4 * (k + 1);
      if (inv_off >= 0) begin
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        inv_sched = c + 2 + inv_off;
      end
      m_valid[idx] = (inv_off < 0);
      m_tag[idx]   = tg;
    end
    e_ack[ack_cyc]  = 1'b1;
    e_data[ack_cyc] = m_data[idx][off];
    mem_addr   = a;
    mem_submit = 1'b1;
    @(negedge i_clk);
    mem_submit = 1'b0;
    mem_addr   = 16'($urandom);
  endtask

  // Invalidate in the next (idle) cycle
  task automatic inv_idle();
    inv_sched = cyc + 1;
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
  endtask

  initial begin
    int c, ack, k, inv_off, r;
    logic [15:0] a;
    for (int i = 0; i < NCYC; i++) begin
      e_data[i] = '0; e_mba[i] = '0;
    end
    i_rst = 1'b1; mem_submit = 1'b0; mem_addr = '0;

    // Per-cycle compare against the model's expectations
    fork
      forever begin
        @(negedge i_clk);
        if (chk_en && cyc < NCYC) begin
          checks++;
          if ({mem_ack, mem_data, mb_req, mb_addr} !==
              {e_ack[cyc], e_data[cyc], e_req[cyc], e_mba[cyc]}) begin
            errors++;
            $display("FAIL outputs cycle %0d: got ack=%b data=%h req=%b mba=%h expected ack=%b data=%h req=%b mba=%h",
                     cyc, mem_ack, mem_data, mb_req, mb_addr,
                     e_ack[cyc], e_data[cyc], e_req[cyc], e_mba[cyc]);
          end
        end
      end
    join_none

    @(negedge i_clk); @(negedge i_clk);
    chk32("reset mem_ack", 32'(mem_ack), 32'h0);
    chk32("reset mem_data", mem_data, 32'h0);
    chk32("reset mb_req", 32'(mb_req), 32'h0);
    chk32("reset mb_addr", 32'(mb_addr), 32'h0);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk_en = 1'b1;

    // First miss: line 0 with a zero-wait backing memory
    c = cyc;
    submit(16'h0000, 0, -1, ack);
    chk32("miss latency 0000", 32'(ack - c), 32'd6);
    for (int b = 0; b < 4; b++) begin
      run_to(c + 2 + b);
      chk32("refill mb_addr", 32'(mb_addr), 32'(b));
    end
    run_to(ack);
    chk32("ack 0000", 32'(mem_ack), 32'h1);
    chk32("data 0000", mem_data, 32'hA5A50000);

    // Back-to-back hits on the same line
    for (int i = 1; i < 4; i++) begin
      c = cyc;
      submit(16'(i), 0, -1, ack);
      chk32("hit latency", 32'(ack - c), 32'd1);
      chk32("b2b data", mem_data, 32'hA5A50000 ^ 32'(i));
    end

    // Conflicting tag on index 0, then the evicted line again
    run_to(ack);
    c = cyc;
    submit(16'h0040, 0, -1, ack);
    chk32("miss latency 0040", 32'(ack - c), 32'd6);
    run_to(ack);
    chk32("data 0040", mem_data, 32'hA5A50040);
    c = cyc;
    submit(16'h0000, 0, -1, ack);
    chk32("re-miss latency 0000", 32'(ack - c), 32'd6);
    run_to(ack);

    // Invalidate during beat 2: ack still delivered, line left invalid
    c = cyc;
    submit(16'h0010, 0, 2, ack);
    run_to(ack);
    chk32("data 0010 after inv", mem_data, 32'hA5A50010);
    c = cyc;
    submit(16'h0011, 0, -1, ack);
    chk32("miss latency 0011", 32'(ack - c), 32'd6);
    run_to(ack);

    // Reset in the middle of a refill, with mb_ack stuck high
    c = cyc;
    submit(16'h0020, 2, -1, ack);
    run_to(c + 6);
    chk_en = 1'b0;
    for (int i = cyc; i < NCYC; i++) begin
      e_ack[i] = 1'b0; e_data[i] = '0; e_req[i] = 1'b0; e_mba[i] = '0;
    end
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    i_rst = 1'b1;
    force_ack = 1'b1;
    #1;
    chk32("mid-reset mem_ack", 32'(mem_ack), 32'h0);
    chk32("mid-reset mb_req", 32'(mb_req), 32'h0);
    chk32("mid-reset mb_addr", 32'(mb_addr), 32'h0);
    @(negedge i_clk); @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk_en = 1'b1;
    @(negedge i_clk);
    c = cyc;
    submit(16'h0020, 0, -1, ack);
    chk32("miss latency after reset", 32'(ack - c), 32'd6);
    run_to(ack);
    chk32("data 0020", mem_data, 32'hA5A50020);
    force_ack = 1'b0;
    @(negedge i_clk);

    // Slow backing memory and the top-of-memory line
    c = cyc;
    submit(16'hFFFE, 3, -1, ack);
    chk32("miss latency k3", 32'(ack - c), 32'd18);
    run_to(c + 2);  chk32("wrap mba first", 32'(mb_addr), 32'h0000FFFC);
    run_to(c + 5);  chk32("wrap mba hold", 32'(mb_addr), 32'h0000FFFC);
    run_to(c + 6);  chk32("wrap mba next", 32'(mb_addr), 32'h0000FFFD);
    run_to(c + 17); chk32("wrap mba last", 32'(mb_addr), 32'h0000FFFF);
    run_to(ack);
    chk32("data FFFE", mem_data, 32'hA5A5FFFE);

    // Random traffic over a small tag pool
    while (cyc < NCYC - 80) begin
      r = $urandom_range(0, 99);
      if (r < 5) inv_idle();
      else if (r < 8) salt = 16'($urandom);
      a = {10'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      k = $urandom_range(0, 3);
      inv_off = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4 * (k + 1) - 2) : -1;
      submit(a, k, inv_off, ack);
      if ($urandom_range(0, 1) == 0) run_to(ack);
      else run_to(ack + $urandom_range(1, 3));
    end

    run_to(cyc + 5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
